// File: rtl/multiplication_pkg.sv
// ---------------------------------------------------------------------------
// multiplication_pkg
// Shared ALU definitions. The control unit drives the divider and the
// multiplier through the same four-state sequence, so the state constants
// live here and are reused by both blocks.
//   ST_IDLE / ST_LOAD / ST_EXEC / ST_STORE : 2-bit state encodings
//   DEFAULT_WIDTH                          : default operand width
// ---------------------------------------------------------------------------
package multiplication_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_STORE = 2'd3;

  localparam int DEFAULT_WIDTH = 8;

  // Counter width for an iteration count of 'width' steps (0 .. width-1).
  function automatic int cnt_bits(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/multiplication_datapath_step.sv
// ---------------------------------------------------------------------------
// mul_datapath_step
// One combinational shift-add step of the multiplier.
//   mcand   [WIDTH-1:0]   multiplicand
//   acc_in  [2*WIDTH-1:0] {hi, lo} accumulator before the step
//   acc_out [2*WIDTH-1:0] {carry, hi', lo} >> 1 after the step
// The add is done at WIDTH+1 bits so the carry moves into the top bit of
// hi on the shift instead of being dropped.
// ---------------------------------------------------------------------------
module mul_datapath_step
  import multiplication_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]   mcand,
  input  logic [2*WIDTH-1:0] acc_in,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] wide;

  always_comb begin
    sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]};
    if (acc_in[0]) begin
      sum = sum + {1'b0, mcand};
    end
    wide    = {sum, acc_in[WIDTH-1:0]};
    // Logical shift right of the full 2*WIDTH+1-bit value; bit 0 is the
    // consumed multiplier bit and falls off.
    acc_out = wide[2*WIDTH:1];
  end

endmodule

// File: rtl/multiplication.sv
// ---------------------------------------------------------------------------
// multiplication
// Sequential shift-add unsigned multiplier with wakeup/done handshake.
//   clk                    system clock
//   rstn                   synchronous reset, active HIGH (rstn=1 resets)
//   num1  [WIDTH-1:0]      multiplicand, sampled in LOAD
//   num2  [WIDTH-1:0]      multiplier, sampled in LOAD
//   multiplication_wakeup  start request, looked at in IDLE and STORE
//   product [2*WIDTH-1:0]  registered result, held between operations
//   done                   high for the single STORE cycle
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for wakeup; product holds
// LOAD  | capture operands, clear accumulator high half and counter
// EXEC  | WIDTH shift-add steps; last step writes product
// STORE | done=1; wakeup here restarts directly into LOAD
// ---------------------------------------------------------------------------
module multiplication
  import multiplication_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [WIDTH-1:0]     num1,
  input  logic [WIDTH-1:0]     num2,
  input  logic                 multiplication_wakeup,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done
);

  localparam int              CW       = cnt_bits(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  logic [1:0]           state;
  logic [WIDTH-1:0]     mcand_reg;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [CW-1:0]        cnt;

  mul_datapath_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .mcand   (mcand_reg),
    .acc_in  (acc),
    .acc_out (acc_next)
  );

  always_ff @(posedge clk) begin
    if (rstn) begin
      state     <= ST_IDLE;
      mcand_reg <= '0;
      acc       <= '0;
      cnt       <= '0;
      product   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (multiplication_wakeup) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          mcand_reg <= num1;
          acc       <= {{WIDTH{1'b0}}, num2};
          cnt       <= '0;
          state     <= ST_EXEC;
        end
        ST_EXEC: begin
          acc <= acc_next;
          cnt <= cnt + CNT_ONE;
          // Product is taken from the step output so it is valid in the
          // STORE cycle itself, not one cycle later.
          if (cnt == CNT_LAST) begin
            product <= acc_next;
            state   <= ST_STORE;
          end
        end
        ST_STORE: begin
          state <= multiplication_wakeup ? ST_LOAD : ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign done = (state == ST_STORE);

endmodule
